// File: rtl/alu_chunked.sv
// alu_chunked: multi-cycle ALU (ADD/SUB/AND/XOR) that processes CHUNK bits per cycle.
// The carry ripples between chunks through a register, so the result is bit-identical
// to a single-cycle WIDTH-bit implementation. Valid/ready handshake on both sides.
module alu_chunked #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             ovf,
   output logic             zf,
   output logic             sf,
   output logic             cf
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   localparam logic [1:0] OpAdd = 2'b00;
   localparam logic [1:0] OpSub = 2'b01;
   localparam logic [1:0] OpAnd = 2'b10;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] acc_q;

   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK:0]   sum;
   logic [CHUNK-1:0] chunk_res;
   logic [WIDTH-1:0] acc_next;
   logic             last;
   logic             arith;
   logic             ovf_next;
   logic             cf_next;

   assign in_ready = (state_q == StIdle);

   // Per-chunk datapath: slice the captured operands, add with the rippled carry.
   always_comb begin
      a_chunk   = a_q[int'(cnt_q)*CHUNK +: CHUNK];
      b_chunk   = b_q[int'(cnt_q)*CHUNK +: CHUNK];
      arith     = (op_q == OpAdd) || (op_q == OpSub);
      // SUB is a + ~b + 1; the +1 arrives as the initial carry-in.
      sum       = {1'b0, a_chunk} + {1'b0, (op_q == OpSub) ? ~b_chunk : b_chunk}
                  + {{CHUNK{1'b0}}, carry_q};
      case (op_q)
         OpAdd, OpSub: chunk_res = sum[CHUNK-1:0];
         OpAnd:        chunk_res = a_chunk & b_chunk;
         default:      chunk_res = a_chunk ^ b_chunk;
      endcase
      acc_next = acc_q;
      acc_next[int'(cnt_q)*CHUNK +: CHUNK] = chunk_res;
      last     = (int'(cnt_q) == NCHUNK - 1);
      cf_next  = arith ? sum[CHUNK] : 1'b0;
      // Overflow uses the original b sign for both ADD and SUB.
      case (op_q)
         OpAdd:   ovf_next = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                             (acc_next[WIDTH-1] != a_q[WIDTH-1]);
         OpSub:   ovf_next = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                             (acc_next[WIDTH-1] != a_q[WIDTH-1]);
         default: ovf_next = 1'b0;
      endcase
   end

   // Control FSM with registered result, flags and out_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         carry_q   <= 1'b0;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         result    <= '0;
         ovf       <= 1'b0;
         zf        <= 1'b0;
         sf        <= 1'b0;
         cf        <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b;
                  op_q    <= op;
                  cnt_q   <= '0;
                  carry_q <= (op == OpSub);
                  acc_q   <= '0;
                  state_q <= StRun;
               end
            end
            StRun: begin
               acc_q   <= acc_next;
               carry_q <= sum[CHUNK];
               if (last) begin
                  cnt_q     <= '0;
                  result    <= acc_next;
                  ovf       <= ovf_next;
                  zf        <= (acc_next == '0);
                  sf        <= acc_next[WIDTH-1];
                  cf        <= cf_next;
                  out_valid <= 1'b1;
                  state_q   <= StDone;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/alu_chunked.md
ALU_CHUNKED -- requirements
Module: alu_chunked

Interface
REQ-001 Parameter WIDTH, default 64, operand/result width in bits.
REQ-002 Parameter CHUNK, default 16, bits processed per cycle; WIDTH SHALL be an integer multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op  input  2  00 ADD (a+b), 01 SUB (a-b), 10 AND, 11 XOR.
REQ-008 a, b  input  WIDTH  signed two's-complement operands.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  WIDTH  signed result.
REQ-012 ovf  output  1  signed overflow flag.
REQ-013 zf, sf  output  1 each  zero flag, sign flag (result[WIDTH-1]).
REQ-014 cf  output  1  carry out of MSB (ADD); not-borrow (SUB, carry of a+~b+1).

Function
REQ-015 FSM states IDLE, RUN, DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 Accept: in_valid & in_ready at an edge captures a, b, op into internal registers and enters RUN with chunk counter = 0, carry-in = 1 for SUB else 0; later changes to a, b, op SHALL have no effect.
REQ-017 in_valid outside IDLE SHALL be ignored (no capture, no state change).
REQ-018 RUN: each edge processes chunk k (bits k*CHUNK .. k*CHUNK+CHUNK-1) of captured operands, SUB using ~b; carry out of chunk k SHALL feed chunk k+1.
REQ-019 Counter increments once per RUN cycle; after processing chunk NCHUNK-1 the FSM SHALL enter DONE (counter returns to 0, no wrap into a stale chunk).
REQ-020 Latency: out_valid SHALL rise exactly NCHUNK edges after the accepting edge (4 for defaults).
REQ-021 result SHALL equal the WIDTH-bit truncation of the selected op, bit-identical to a single-cycle implementation.
REQ-022 ovf: ADD = (a[MSB]==b[MSB]) & (result[MSB]!=a[MSB]); SUB = (a[MSB]!=b[MSB]) & (result[MSB]!=a[MSB]); AND/XOR = 0.
REQ-023 cf SHALL be 0 for AND/XOR; zf = (result == 0) for all ops.
REQ-024 DONE: out_valid = 1; result and flags SHALL be stable while out_valid & !out_ready.
REQ-025 out_valid & out_ready at an edge SHALL return FSM to IDLE; out_valid drops next cycle; no new request is accepted in that same edge.
REQ-026 out_valid SHALL be 0 in IDLE and RUN; result/flags hold last completed values outside DONE (undefined to the consumer).
REQ-027 NCHUNK = 1 (CHUNK = WIDTH) SHALL be supported: RUN lasts one cycle, latency 1.

Reset
REQ-028 rst high at an edge SHALL force IDLE, counter 0, carry 0, result 0, ovf/zf/sf/cf 0, out_valid 0, in_ready 1 the following cycle, regardless of state.
REQ-029 rst during RUN or DONE SHALL abort the operation; no out_valid SHALL be produced for it.
REQ-030 rst has priority over in_valid and out_ready in the same cycle.

Verification
REQ-031 ADD a=10, b=-15 -> after 4 cycles result=-5, ovf=0, sf=1, zf=0, cf=0; a=15, b=-10 -> 5, cf=1; a=10, b=-10 -> 0, zf=1, cf=1.
REQ-032 ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> result=0x8000_0000_0000_0000, ovf=1, sf=1; ADD a=b=0x8000_0000_0000_0000 -> result=0, ovf=1, zf=1, cf=1.
REQ-033 SUB a=0x8000_0000_0000_0000, b=1 -> result=0x7FFF_FFFF_FFFF_FFFF, ovf=1, sf=0; SUB a=b=5 -> 0, zf=1, cf=1; AND a=0xF0F0, b=0xFF00 -> 0xF000, ovf=0; XOR a=b -> 0, zf=1.
REQ-034 Carry ripple across chunk boundaries: a=0x0000_0000_0000_FFFF, b=1 -> 0x10000; a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> 0, cf=1, zf=1, ovf=0.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and changing a/b -> result/flags stable, in_ready=0, no capture; raise out_ready -> IDLE next cycle, then new request accepted.
REQ-036 Reset mid-operation: assert rst 2 cycles after accept -> next cycle in_ready=1, out_valid=0, all outputs 0; repeat all checks with WIDTH=32, CHUNK=8 and WIDTH=CHUNK=16 against a reference model.
